mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store engine between the multicycle controller and the data memory port. It replaces the fixed 32-bit byte/half/word paths with one block that:
- accepts a single access command;
- checks alignment;
- drives a variable-latency memory request/acknowledge handshake with byte enables and a timeout;
- returns lane-aligned, sign- or zero-extended read data with an error code.

## Interface

Parameters:
- XLEN, 32 — data width; legal values 32 or 64.
- ADDR_W, 32 — byte address width.
- TIMEOUT, 255 — maximum cycles waiting for mem_ack/mem_err; 0 disables the timeout.

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-low (0 = reset).
- cmd_valid  in  1  — command present.
- cmd_ready  out  1  — high only in IDLE.
- cmd_write  in  1  — 1 = store, 0 = load.
- cmd_size  in  2  — 00 byte, 01 half, 10 word, 11 dword.
- cmd_unsigned  in  1  — load zero-extends when 1.
- cmd_addr  in  ADDR_W  — byte address.
- cmd_wdata  in  XLEN  — store data, right-justified.
- rsp_valid  out  1  — response held until accepted.
- rsp_ready  in  1  — response accepted.
- rsp_rdata  out  XLEN  — extended load data; 0 for stores and errors.
- rsp_err  out  2  — 00 ok, 01 misaligned/illegal size, 10 timeout, 11 bus error.
- mem_req  out  1  — memory request.
- mem_we  out  1  — write strobe.
- mem_addr  out  ADDR_W  — address aligned down to XLEN/8 bytes.
- mem_be  out  XLEN/8  — byte enables, little-endian.
- mem_wdata  out  XLEN  — replicated store data.
- mem_rdata  in  XLEN  — read data, valid with mem_ack.
- mem_ack  in  1  — access complete.
- mem_err  in  1  — access failed.

## Operation

FSM states: IDLE, REQ, RESP.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch all cmd_* fields.
  - Illegal size (11 with XLEN=32) or misalignment (addr not a multiple of 2^size) -> RESP with err=01; mem_req is never raised.
  - Otherwise -> REQ; clear the timeout counter.
- **REQ**
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are stable for the whole state.
  - mem_err -> RESP, err=11. mem_err wins over a simultaneous mem_ack.
  - mem_ack -> RESP, err=00; capture the extracted read data.
  - Counter reaches TIMEOUT with neither ack nor err -> RESP, err=10. An ack in the same cycle as the timeout wins.
- **RESP**
  - rsp_valid=1; rsp_* stable.
  - On rsp_ready -> IDLE.
- **Lane rules**
  - Lane index = addr[log2(XLEN/8)-1:0].
  - mem_be = (2^(2^size)-1) << lane.
  - mem_wdata: the low 2^size bytes of cmd_wdata replicated across the bus.
  - Loads: bytes at the lane, shifted to bit 0, extended from bit 8·2^size−1. Extension is zero when cmd_unsigned=1, or when size equals XLEN/8 bytes.
- **Ignored inputs**: mem_ack and mem_err outside REQ; cmd_valid outside IDLE.
- **Reset**: state=IDLE, counter=0, all outputs 0 except cmd_ready=1. Reset mid-REQ drops mem_req immediately and never produces a response.

## Timing

- Command accepted at edge 0; mem_req is high from cycle 1.
- An ack in cycle k gives rsp_valid from cycle k+1.
- Minimum load/store latency is 2 cycles (ack in the first REQ cycle).
- Misaligned/illegal commands: rsp_valid in cycle 1.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then rsp_valid the next cycle.
- Back-to-back throughput: one command per 3 cycles minimum. cmd_ready rises the cycle after rsp_valid&rsp_ready.
- All outputs are registered or decoded from registered state only. There is no combinational path from mem_ack to cmd_ready.

## Structure

- Package mau_pkg holds:
  - size encodings (SZ_B/H/W/D);
  - error codes (ERR_OK/ALIGN/TIMEOUT/BUS);
  - the state enum.
- One sub-module, lane_align: combinational read extraction and extension (mem_rdata, lane, size, unsigned -> XLEN). It is instantiated once and reused by any future cache fill path.

## Test plan

- XLEN=32, load byte signed, addr 0x1003, mem_rdata 0x80FF_FF00, ack in the first cycle -> mem_be=1000, rsp_rdata=0xFFFF_FF80, err=00, rsp_valid 2 cycles after acceptance.
- Store half, addr 0x2002, wdata 0x0000_ABCD -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1 until ack.
- Load word at 0x3001 -> no mem_req, rsp_valid in cycle 1 with err=01. Size 11 with XLEN=32 -> err=01.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then err=10. Repeat with ack in cycle 4 -> err=00. mem_ack and mem_err together -> err=11.
- XLEN=64, load word unsigned at 0x...4, mem_rdata 0x8765_4321_xxxx_xxxx -> rsp_rdata=0x0000_0000_8765_4321. Also: rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
- Reset asserted mid-REQ (cycle 2) -> mem_req=0 and cmd_ready=1 asynchronously, no rsp_valid. The next command completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, response codes, FSM states.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_BUS     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // An address is misaligned when any bit below the access size is set.
  function automatic logic addr_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] low_mask;
    low_mask = 3'((4'd1 << size) - 4'd1);
    return |(addr_lo & low_mask);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Read-data extraction: pick the addressed lane, move it to bit 0, sign- or zero-extend.
module lane_align
  import mau_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned LANE_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [XLEN-1:0]   ext_c
);

  localparam logic [XLEN-1:0] ONES = '1;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;
  int unsigned     nbits;

  // Shift the lane down, keep 8*2^size bits, fill the rest with the sign (or zero).
  // A full-width access shifts the mask out entirely, so no extension happens.
  always_comb begin
    shifted   = rdata >> {lane, 3'b000};
    nbits     = 32'd8 << size;
    keep_mask = ~(ONES << nbits);
    case (size)
      SZ_B:    sign_bit = shifted[7];
      SZ_H:    sign_bit = shifted[15];
      SZ_W:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    if (is_unsigned) sign_bit = 1'b0;
    ext_c = (shifted & keep_mask) | ({XLEN{sign_bit}} & ~keep_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine: one command at a time, alignment check, memory handshake with
// byte enables and timeout, lane-aligned extended read data with an error code.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [1:0]          cmd_size,
  input  logic                cmd_unsigned,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [XLEN-1:0]     cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack,
  input  logic                mem_err
);

  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic              write_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [LANE_W-1:0] lane_q;
  logic [CNT_W-1:0]  tmo_cnt_q;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic [1:0]        rsp_err_q;

  logic              cmd_illegal_c;
  logic              tmo_hit_c;
  logic              req_done_c;
  logic [BE_W-1:0]   be_mask_c;
  logic [BE_W-1:0]   be_new_c;
  logic [XLEN-1:0]   wdata_rep_c;
  logic [LANE_W-1:0] byte_wrap_c;
  logic [XLEN-1:0]   rdata_ext_c;

  // Dword only exists on a 64-bit bus; every size must be naturally aligned.
  assign cmd_illegal_c = ((cmd_size == SZ_D) && (XLEN < 64)) ||
                         addr_misaligned(cmd_addr[2:0], cmd_size);

  // Timeout fires in the TIMEOUT-th REQ cycle; TIMEOUT of 0 waits forever.
  assign tmo_hit_c  = (TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
  assign req_done_c = mem_err || mem_ack || tmo_hit_c;

  // Byte enables and replicated store data for the incoming command.
  always_comb begin
    be_mask_c   = '0;
    wdata_rep_c = '0;
    byte_wrap_c = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      be_mask_c[i] = (i < (1 << cmd_size));
      byte_wrap_c  = LANE_W'(i) & LANE_W'((1 << cmd_size) - 1);
      wdata_rep_c[i*8 +: 8] = cmd_wdata[{byte_wrap_c, 3'b000} +: 8];
    end
  end

  assign be_new_c = be_mask_c << cmd_addr[LANE_W-1:0];

  lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .rdata       (mem_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .ext_c       (rdata_ext_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; bus error beats ack, ack beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_illegal_c ? RESP : REQ;
      REQ:     if (req_done_c) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      REQ:     mem_req   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Command latch, memory request payload, timeout counter and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q     <= 1'b0;
      size_q      <= SZ_B;
      unsigned_q  <= 1'b0;
      lane_q      <= '0;
      tmo_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            write_q    <= cmd_write;
            size_q     <= cmd_size;
            unsigned_q <= cmd_unsigned;
            lane_q     <= cmd_addr[LANE_W-1:0];
            tmo_cnt_q  <= '0;
            if (cmd_illegal_c) begin
              rsp_err_q   <= ERR_ALIGN;
              rsp_rdata_q <= '0;
            end else begin
              mem_we_q    <= cmd_write;
              mem_addr_q  <= {cmd_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
              mem_be_q    <= be_new_c;
              mem_wdata_q <= wdata_rep_c;
            end
          end
        end
        REQ: begin
          if (TIMEOUT != 0) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          if (req_done_c) begin
            mem_we_q <= 1'b0;
            mem_be_q <= '0;
          end
          if (mem_err) begin
            rsp_err_q   <= ERR_BUS;
            rsp_rdata_q <= '0;
          end else if (mem_ack) begin
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= write_q ? '0 : rdata_ext_c;
          end else if (tmo_hit_c) begin
            rsp_err_q   <= ERR_TIMEOUT;
            rsp_rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance (TIMEOUT=4) driven from
// shared command/memory signals, checked against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write, cmd_unsigned, rsp_ready, mem_ack, mem_err;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata, mem_rdata;
  logic        sel64;

  logic        cr32, rv32, mq32, mw32;
  logic [1:0]  re32;
  logic [31:0] rd32, ma32, md32;
  logic [3:0]  mb32;
  logic        cr64, rv64, mq64, mw64;
  logic [1:0]  re64;
  logic [63:0] rd64, md64;
  logic [31:0] ma64;
  logic [7:0]  mb64;

  logic        o_cmd_ready, o_rsp_valid, o_mem_req, o_mem_we;
  logic [1:0]  o_rsp_err;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid & ~sel64), .cmd_ready(cr32), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_unsigned(cmd_unsigned), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata[31:0]), .rsp_valid(rv32), .rsp_ready(rsp_ready),
    .rsp_rdata(rd32), .rsp_err(re32), .mem_req(mq32), .mem_we(mw32),
    .mem_addr(ma32), .mem_be(mb32), .mem_wdata(md32), .mem_rdata(mem_rdata[31:0]),
    .mem_ack(mem_ack), .mem_err(mem_err)
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid & sel64), .cmd_ready(cr64), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_unsigned(cmd_unsigned), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv64), .rsp_ready(rsp_ready),
    .rsp_rdata(rd64), .rsp_err(re64), .mem_req(mq64), .mem_we(mw64),
    .mem_addr(ma64), .mem_be(mb64), .mem_wdata(md64), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err)
  );

  assign o_cmd_ready = sel64 ? cr64 : cr32;
  assign o_rsp_valid = sel64 ? rv64 : rv32;
  assign o_mem_req   = sel64 ? mq64 : mq32;
  assign o_mem_we    = sel64 ? mw64 : mw32;
  assign o_rsp_err   = sel64 ? re64 : re32;
  assign o_rsp_rdata = sel64 ? rd64 : {32'b0, rd32};
  assign o_mem_wdata = sel64 ? md64 : {32'b0, md32};
  assign o_mem_addr  = sel64 ? ma64 : ma32;
  assign o_mem_be    = sel64 ? mb64 : {4'b0, mb32};

  // Reference model: plain arithmetic on bus width, access size and address.
  function automatic bit m_illegal(input bit is64, input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3 && !is64) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
  endfunction

  function automatic logic [7:0] m_be(input bit is64, input logic [1:0] sz, input logic [31:0] a);
    int bb, nb, lane;
    logic [15:0] v;
    bb = is64 ? 8 : 4;
    nb = 1 << sz;
    lane = int'(a & 32'(bb - 1));
    v = ((16'd1 << nb) - 16'd1) << lane;
    return v[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input bit is64, input logic [1:0] sz, input logic [63:0] wd);
    int bb, nb;
    logic [63:0] v;
    bb = is64 ? 8 : 4;
    nb = 1 << sz;
    v = '0;
    for (int i = 0; i < bb; i++) v[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input bit is64, input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [63:0] rd);
    int bb, nb, lane;
    logic [63:0] v, mask, bus;
    bb = is64 ? 8 : 4;
    nb = 1 << sz;
    lane = int'(a & 32'(bb - 1));
    bus = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v = (rd & bus) >> (8 * lane);
    if (nb < bb) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (!uns && v[8*nb-1]) v = v | (~mask & bus);
    end
    return v;
  endfunction

  // One complete command: accept, REQ phase with optional ack/err in REQ cycle ack_cyc,
  // response held for 'hold' cycles, then released.
  task automatic do_access(input bit is64, input bit w, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                           input int ack_cyc, input bit ack, input bit err, input int hold,
                           input string tag);
    bit ill;
    logic [1:0] e_err;
    logic [63:0] e_data, e_wd;
    logic [31:0] e_addr;
    logic [7:0] e_be;
    ill    = m_illegal(is64, sz, a);
    e_addr = a & ~32'(is64 ? 7 : 3);
    e_be   = m_be(is64, sz, a);
    e_wd   = m_wdata(is64, sz, wd);
    if (ill) begin
      e_err = 2'b01; e_data = '0;
    end else if (ack_cyc >= 1 && ack_cyc <= int'(TMO) && (ack || err)) begin
      e_err  = err ? 2'b11 : 2'b00;
      e_data = (err || w) ? 64'd0 : m_load(is64, sz, uns, a, rd);
    end else begin
      e_err = 2'b10; e_data = '0;
    end
    @(negedge clk);
    sel64 = is64;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s idle_ready: got %b expected 1", tag, o_cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_unsigned = uns;
    cmd_addr = a; cmd_wdata = wd;
    @(negedge clk);
    // Scramble the command bus after acceptance; the unit must use its latched copy.
    cmd_valid = 1'b0; cmd_write = ~w; cmd_size = 2'($urandom); cmd_unsigned = ~uns;
    cmd_addr = $urandom; cmd_wdata = {$urandom, $urandom};
    if (!ill) begin
      for (int n = 1; n <= int'(TMO); n++) begin
        checks++;
        if (o_mem_req !== 1'b1 || o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s req_phase cyc%0d: req=%b rsp_valid=%b ready=%b expected 1/0/0",
                   tag, n, o_mem_req, o_rsp_valid, o_cmd_ready);
        end
        checks++;
        if (o_mem_we !== w || o_mem_addr !== e_addr || o_mem_be !== e_be) begin
          failures++;
          $display("FAIL %s req_payload cyc%0d: we=%b addr=%h be=%b expected we=%b addr=%h be=%b",
                   tag, n, o_mem_we, o_mem_addr, o_mem_be, w, e_addr, e_be);
        end
        if (w) begin
          checks++;
          if (o_mem_wdata !== e_wd) begin
            failures++;
            $display("FAIL %s mem_wdata cyc%0d: got %h expected %h", tag, n, o_mem_wdata, e_wd);
          end
        end
        if (n == ack_cyc) begin
          mem_ack = ack; mem_err = err; mem_rdata = rd;
        end else begin
          mem_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_err = 1'b0;
        if (n == ack_cyc && (ack || err)) break;
      end
    end
    checks++;
    if (o_rsp_valid !== 1'b1 || o_mem_req !== 1'b0 || o_cmd_ready !== 1'b0 || o_mem_we !== 1'b0) begin
      failures++;
      $display("FAIL %s rsp_phase: rsp_valid=%b req=%b ready=%b we=%b expected 1/0/0/0",
               tag, o_rsp_valid, o_mem_req, o_cmd_ready, o_mem_we);
    end
    checks++;
    if (o_rsp_err !== e_err) begin
      failures++; $display("FAIL %s rsp_err: got %b expected %b", tag, o_rsp_err, e_err);
    end
    checks++;
    if (o_rsp_rdata !== e_data) begin
      failures++; $display("FAIL %s rsp_rdata: got %h expected %h", tag, o_rsp_rdata, e_data);
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      mem_ack = 1'b1; mem_err = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_err !== e_err || o_rsp_rdata !== e_data || o_cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s rsp_hold%0d: valid=%b err=%b data=%h ready=%b expected 1/%b/%h/0",
                 tag, h, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_cmd_ready, e_err, e_data);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: rsp_valid=%b ready=%b expected 0/1", tag, o_rsp_valid, o_cmd_ready);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      checks++;
      if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctrl x%0d: ready=%b rsp_valid=%b req=%b we=%b expected 1/0/0/0",
                 s, o_cmd_ready, o_rsp_valid, o_mem_req, o_mem_we);
      end
      checks++;
      if (o_rsp_err !== 2'b00 || o_rsp_rdata !== 64'd0 || o_mem_addr !== 32'd0 ||
          o_mem_be !== 8'd0 || o_mem_wdata !== 64'd0) begin
        failures++;
        $display("FAIL reset_data x%0d: err=%b rdata=%h addr=%h be=%b wdata=%h expected zeros",
                 s, o_rsp_err, o_rsp_rdata, o_mem_addr, o_mem_be, o_mem_wdata);
      end
    end
  endtask

  task automatic test_spec_vectors();
    do_access(0, 0, 2'd0, 0, 32'h0000_1003, 64'd0, 64'h0000_0000_80FF_FF00, 1, 1, 0, 0, "lb_signed");
    do_access(0, 1, 2'd1, 0, 32'h0000_2002, 64'h0000_ABCD, 64'd0, 3, 1, 0, 0, "sh_store");
    do_access(0, 0, 2'd1, 1, 32'h0000_2006, 64'd0, 64'h0000_0000_9876_5432, 1, 1, 0, 1, "lhu");
  endtask

  task automatic test_misaligned();
    do_access(0, 0, 2'd2, 0, 32'h0000_3001, 64'd0, 64'd0, 1, 1, 0, 0, "lw_misaligned");
    do_access(0, 0, 2'd3, 0, 32'h0000_3000, 64'd0, 64'd0, 1, 1, 0, 0, "dword_on_32");
    do_access(0, 1, 2'd1, 0, 32'h0000_3003, 64'h1234, 64'd0, 1, 1, 0, 1, "sh_odd");
  endtask

  task automatic test_timeout();
    do_access(0, 0, 2'd2, 0, 32'h0000_4000, 64'd0, 64'd0, 0, 0, 0, 0, "timeout");
    do_access(0, 0, 2'd2, 0, 32'h0000_4004, 64'd0, 64'h0000_0000_CAFE_F00D, 4, 1, 0, 0, "ack_at_limit");
    do_access(0, 0, 2'd2, 0, 32'h0000_4008, 64'd0, 64'h0000_0000_1111_2222, 1, 1, 1, 0, "ack_and_err");
    do_access(0, 1, 2'd0, 0, 32'h0000_4009, 64'h5A, 64'd0, 3, 0, 1, 0, "bus_err");
  endtask

  task automatic test_xlen64();
    do_access(1, 0, 2'd2, 1, 32'h0000_1004, 64'd0, 64'h8765_4321_DEAD_BEEF, 1, 1, 0, 5, "lwu_64");
    do_access(1, 0, 2'd2, 0, 32'h0000_1004, 64'd0, 64'h8765_4321_DEAD_BEEF, 2, 1, 0, 0, "lw_64");
    do_access(1, 0, 2'd3, 0, 32'h0000_1008, 64'd0, 64'hF000_0000_0000_0001, 1, 1, 0, 0, "ld_64");
    do_access(1, 1, 2'd3, 0, 32'h0000_1010, 64'h0123_4567_89AB_CDEF, 64'd0, 2, 1, 0, 0, "sd_64");
    do_access(1, 0, 2'd0, 0, 32'h0000_1017, 64'd0, 64'h9100_0000_0000_0000, 1, 1, 0, 0, "lb_lane7");
    do_access(1, 0, 2'd3, 0, 32'h0000_100C, 64'd0, 64'd0, 1, 1, 0, 0, "ld_misaligned");
  endtask

  task automatic test_random();
    bit is64, w, uns, ack, err;
    logic [1:0] sz;
    logic [31:0] a;
    int ack_cyc, r, hold;
    for (int it = 0; it < 60; it++) begin
      is64 = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      ack_cyc = $urandom_range(1, TMO + 1);
      r    = $urandom_range(0, 3);
      ack  = (r != 1);
      err  = (r == 1 || r == 2);
      hold = $urandom_range(0, 2);
      do_access(is64, w, sz, uns, a, {$urandom, $urandom}, {$urandom, $urandom},
                ack_cyc, ack, err, hold, $sformatf("rand%0d", it));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int nresp;
    v = $urandom;
    @(negedge clk);
    sel64 = 1'b0;
    #1;
    cmd_write = 1'b0; cmd_size = 2'd2; cmd_unsigned = 1'b0; cmd_addr = 32'h0000_0040;
    mem_rdata = {32'h0, v}; mem_ack = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    nresp = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_rsp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (o_rsp_rdata !== {32'b0, v} || o_rsp_err !== 2'b00) begin
          failures++;
          $display("FAIL b2b_rsp c%0d: data=%h err=%b expected %h/00", c, o_rsp_rdata, o_rsp_err, v);
        end
      end
      if (c % 3 == 2) begin
        checks++;
        if (o_cmd_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_ready c%0d: got %b expected 1", c, o_cmd_ready);
        end
      end
    end
    cmd_valid = 1'b0; mem_ack = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (nresp != 10) begin
      failures++; $display("FAIL b2b_throughput: got %0d responses expected 10", nresp);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    sel64 = 1'b0;
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h0000_5000;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: req=%b ready=%b rsp_valid=%b expected 0/1/0",
               o_mem_req, o_cmd_ready, o_rsp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0 || o_cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL post_reset c%0d: rsp_valid=%b req=%b ready=%b expected 0/0/1",
                 c, o_rsp_valid, o_mem_req, o_cmd_ready);
      end
    end
    mem_ack = 1'b0;
    do_access(0, 0, 2'd1, 0, 32'h0000_5002, 64'd0, 64'h0000_0000_8001_0000, 2, 1, 0, 0, "after_reset");
  endtask

  initial begin
    reset = 1'b0; sel64 = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0; cmd_unsigned = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_spec_vectors();
    test_misaligned();
    test_timeout();
    test_xlen64();
    test_random();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
